serial_adder_fsm: RTL

- Bit-serial N-bit adder built around the existing one-bit gate-level cell full_adder_gate.
- Accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake.
- Feeds the cell one bit per clock, LSB first, and keeps the carry in a flip-flop between bits.
- Assembles the WIDTH-bit sum and final carry, then presents them through a valid/ready output handshake.
- Trades the ripple-carry area of a parallel adder for WIDTH cycles of latency.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/full_adder_gate.sv | 20 ++
 rtl/serial_adder_fsm.sv | 109 ++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - state encoding and sizing helper for the bit-serial adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/full_adder_gate.sv
// rtl/full_adder_gate.sv - one-bit gate-level full adder cell
module full_adder_gate (
    output logic C_out,
    output logic S,
    input  logic A,
    input  logic B,
    input  logic C_in
);

    logic p;
    logic g;
    logic t;

    assign p     = A ^ B;
    assign g     = A & B;
    assign t     = p & C_in;
    assign S     = p ^ C_in;
    assign C_out = g | t;

endmodule

// File: rtl/serial_adder_fsm.sv
// rtl/serial_adder_fsm.sv - WIDTH-bit adder that feeds one full-adder cell LSB first
module serial_adder_fsm
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             busy
);

    localparam int CNT_W = (clog2(WIDTH) < 1) ? 1 : clog2(WIDTH);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   s_sh;
    logic [WIDTH-1:0]   s_next;
    logic [CNT_W-1:0]   cnt;
    logic               carry;
    logic               s_bit;
    logic               c_bit;
    logic               last;

    full_adder_gate u_cell (
        .C_out (c_bit),
        .S     (s_bit),
        .A     (a_sh[0]),
        .B     (b_sh[0]),
        .C_in  (carry)
    );

    // New sum bit enters at the MSB so the LSB-first stream lands in place after WIDTH steps
    assign s_next = (s_sh >> 1) | {s_bit, {(WIDTH-1){1'b0}}};
    assign last   = (cnt == CNT_W'(WIDTH - 1));
    assign busy   = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = ST_ADD;
            end
            ST_ADD: begin
                if (last) state_next = ST_HOLD;
            end
            ST_HOLD: begin
                in_ready = out_ready;
                if (out_ready) state_next = in_valid ? ST_ADD : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh      <= '0;
            b_sh      <= '0;
            s_sh      <= '0;
            cnt       <= '0;
            carry     <= 1'b0;
            S         <= '0;
            C_out     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (state == ST_ADD) begin
                a_sh  <= a_sh >> 1;
                b_sh  <= b_sh >> 1;
                s_sh  <= s_next;
                carry <= c_bit;
                cnt   <= cnt + CNT_W'(1);
                if (last) begin
                    S         <= s_next;
                    C_out     <= c_bit;
                    out_valid <= 1'b1;
                end
            end else if (in_valid && in_ready) begin
                a_sh  <= A;
                b_sh  <= B;
                s_sh  <= '0;
                cnt   <= '0;
                carry <= C_in;
            end
            // S and C_out intentionally keep the last result after the drain
            if (state == ST_HOLD && out_ready) out_valid <= 1'b0;
        end
    end

endmodule
